// File: rtl/bitwise_pkg.sv
// Package: bitwise_pkg
// Shared definitions for the serial bitwise logic unit: the op encodings and
// the control FSM state type.
package bitwise_pkg;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_slice.sv
// Module: logic_slice
// Combinational SLICE-bit bitwise operator. The top level uses a single
// instance for every slice of the operand and steps it across the slices.
// Ports:
//   out  SLICE-bit result of op(a, b)
//   a    slice of operand A
//   b    slice of operand B (ignored for NOT)
//   op   operation select (OP_NOT / OP_AND / OP_OR / OP_XOR)
module logic_slice
    import bitwise_pkg::*;
#(
    parameter int SLICE = 4
) (
    output logic [SLICE-1:0] out,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [1:0]       op
);

    always_comb begin
        out = '0;
        case (op)
            OP_NOT:  out = ~a;
            OP_AND:  out = a & b;
            OP_OR:   out = a | b;
            default: out = a ^ b;
        endcase
    end

endmodule

// File: rtl/serial_bitwise_logic_unit.sv
// Module: serial_bitwise_logic_unit
// Multi-cycle bitwise NOT/AND/OR/XOR unit. Operands are latched on an accepted
// start and processed SLICE bits per cycle, LSB slice first. The result
// register only changes on the last RUN cycle and is held until the next
// completed operation.
// Optional feature: define BITWISE_ZERO_FLAG_EN to add the registered zero
// flag output.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, accepted in IDLE or DONE
//   op      00 NOT a, 01 AND, 10 OR, 11 XOR
//   a, b    WIDTH-bit operands
//   busy    high while processing slices
//   done    one-cycle pulse when result is valid
//   result  WIDTH-bit result
//   zero    result == 0 (only with BITWISE_ZERO_FLAG_EN)
module serial_bitwise_logic_unit
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef BITWISE_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int NUM_SLICES = WIDTH / SLICE;
    localparam int CNT_W      = $clog2(NUM_SLICES) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SLICES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
`ifdef BITWISE_ZERO_FLAG_EN
    logic               zero_q, zero_d;
`endif

    logic [31:0]        shamt;
    logic [WIDTH-1:0]   a_sh, b_sh;
    logic [SLICE-1:0]   slice_out;
    logic [WIDTH-1:0]   acc_merge;

    // Slice selection by shifting avoids an out-of-range part-select when
    // the counter is wider than the slice index needs.
    always_comb begin
        shamt = 32'(idx_q) * 32'(SLICE);
        a_sh  = a_q >> shamt;
        b_sh  = b_q >> shamt;
    end

    logic_slice #(.SLICE(SLICE)) u_slice (
        .out (slice_out),
        .a   (a_sh[SLICE-1:0]),
        .b   (b_sh[SLICE-1:0]),
        .op  (op_q)
    );

    always_comb begin
        acc_merge = (acc_q & ~({{(WIDTH-SLICE){1'b0}}, {SLICE{1'b1}}} << shamt))
                  | ({{(WIDTH-SLICE){1'b0}}, slice_out} << shamt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
`ifdef BITWISE_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
`ifdef BITWISE_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        result_d = result_q;
`ifdef BITWISE_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    op_d  = op;
                    idx_d = '0;
                    acc_d = '0;
                end
            end
            RUN: begin
                acc_d = acc_merge;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    result_d = acc_merge;
`ifdef BITWISE_ZERO_FLAG_EN
                    zero_d   = (acc_merge == '0);
`endif
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        busy   = (state_q == RUN);
        done   = (state_q == DONE);
        result = result_q;
`ifdef BITWISE_ZERO_FLAG_EN
        zero   = zero_q;
`endif
    end

endmodule

// File: tb/tb_serial_bitwise_logic_unit.sv
module tb_serial_bitwise_logic_unit;
    import bitwise_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start8;
    logic [1:0]  op, op8;
    logic [31:0] a, b, result;
    logic [7:0]  a8, b8, result8;
    logic        busy, done, busy8, done8;
`ifdef BITWISE_ZERO_FLAG_EN
    logic        zero, zero8;
`endif

    always #5 clk = ~clk;

    serial_bitwise_logic_unit #(.WIDTH(32), .SLICE(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef BITWISE_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    serial_bitwise_logic_unit #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .op     (op8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .result (result8)
`ifdef BITWISE_ZERO_FLAG_EN
        ,
        .zero   (zero8)
`endif
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        exp_zero;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one op, push its expectation, wait (bounded) for done and score it.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [31:0] e,
                          output int edges, output int busy_cyc);
        logic [31:0] got_exp;
        edges    = 0;
        busy_cyc = 0;
        @(negedge clk);
        op = o; a = aa; b = bb; start = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
            check({name, " busy_done_excl"}, {31'd0, busy & done}, 32'd0);
            if (busy) busy_cyc++;
            if (done) break;
        end
        got_exp = exp_q.pop_front();
        if (!done) check({name, " timeout"}, 32'd0, 32'd1);
        else       check({name, " result"}, result, got_exp);
    endtask

    initial begin
        int edges, busy_cyc, done_cnt;
        logic [31:0] e;

        vecs[0] = '{OP_NOT, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0000, 1'b0};
        vecs[1] = '{OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        vecs[2] = '{OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
        vecs[3] = '{OP_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
        vecs[4] = '{OP_XOR, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[5] = '{OP_NOT, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[6] = '{OP_OR,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[7] = '{OP_AND, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        #12;
        check("reset result", result, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
`ifdef BITWISE_ZERO_FLAG_EN
        check("reset zero", {31'd0, zero}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Table: function, latency (9 edges incl. start edge) and busy width.
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                   edges, busy_cyc);
            check($sformatf("vec%0d edges", i), edges, 32'd9);
            check($sformatf("vec%0d busy_cycles", i), busy_cyc, 32'd8);
`ifdef BITWISE_ZERO_FLAG_EN
            check($sformatf("vec%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].exp_zero});
`endif
        end

        // Operand change and start pulse during RUN are ignored.
        @(negedge clk);
        op = OP_OR; a = 32'h1234_5678; b = 32'h0; start = 1'b1;
        exp_q.push_back(32'h1234_5678);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            start = (i == 3);
            a = 32'h0;
            op = OP_NOT;
            if (i == 2) check("ign held_result", result, 32'h8000_0001);
            if (done) begin
                done_cnt++;
                e = exp_q.pop_front();
                check("ign result", result, e);
            end
        end
        check("ign done_pulses", done_cnt, 32'd1);
        check("ign idle_busy", {31'd0, busy}, 32'd0);

        // Start held through DONE: back-to-back with no IDLE gap.
        @(negedge clk);
        op = OP_NOT; a = 32'h0000_FFFF; b = 32'h0; start = 1'b1;
        exp_q.push_back(32'hFFFF_0000);
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            op = OP_AND; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00;
            edges++;
            if (done) break;
        end
        if (!done) check("b2b first timeout", 32'd0, 32'd1);
        e = exp_q.pop_front();
        check("b2b first result", result, e);
        exp_q.push_back(32'hF000_F000);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b busy_after_done", {31'd0, busy}, 32'd1);
        check("b2b done_cleared", {31'd0, done}, 32'd0);
        edges = 1;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
            edges++;
        end
        e = exp_q.pop_front();
        if (!done) check("b2b second timeout", 32'd0, 32'd1);
        else       check("b2b second result", result, e);
        check("b2b second edges", edges, 32'd9);

        // Async reset mid-RUN.
        run_op("pre_rst", OP_NOT, 32'h5555_5555, 32'h0, 32'hAAAA_AAAA, edges, busy_cyc);
        @(negedge clk);
        op = OP_OR; a = 32'hFFFF_FFFF; b = 32'h0; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("rst busy_before", {31'd0, busy}, 32'd1);
        check("rst held_result", result, 32'hAAAA_AAAA);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", OP_XOR, 32'h0F0F_0F0F, 32'hFFFF_0000, 32'hF0F0_0F0F, edges, busy_cyc);
        check("post_rst edges", edges, 32'd9);

        // Single-slice configuration: done on the 2nd edge counting the start edge.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            op8 = (k == 0) ? OP_XOR : OP_AND;
            a8  = (k == 0) ? 8'h3C : 8'h0F;
            b8  = (k == 0) ? 8'hFF : 8'hF3;
            e   = (k == 0) ? 32'h0000_00C3 : 32'h0000_0003;
            start8 = 1'b1;
            edges = 0;
            busy_cyc = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                start8 = 1'b0;
                edges++;
                if (busy8) busy_cyc++;
                if (done8) break;
            end
            check($sformatf("w8_%0d edges", k), edges, 32'd2);
            check($sformatf("w8_%0d busy_cycles", k), busy_cyc, 32'd1);
            check($sformatf("w8_%0d result", k), {24'd0, result8}, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
